// File: rtl/soc_pkg.sv
// rtl/soc_pkg.sv - shared watchdog types, CSR map and kick key
package soc_pkg;

  localparam int WDT_TIMEOUT_W = 24;

  typedef logic [WDT_TIMEOUT_W-1:0] cnt_wdt_t;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    RUNNING  = 2'd1,
    WARN     = 2'd2,
    BITE     = 2'd3
  } wdt_state_t;

  localparam logic [31:0] WDT_KICK_KEY = 32'h5A5A_A5A5;

  localparam logic [1:0] WDT_ADDR_CTRL    = 2'd0;
  localparam logic [1:0] WDT_ADDR_TIMEOUT = 2'd1;
  localparam logic [1:0] WDT_ADDR_KICK    = 2'd2;
  localparam logic [1:0] WDT_ADDR_STATUS  = 2'd3;

endpackage

// File: rtl/wdt_csr.sv
// rtl/wdt_csr.sv - watchdog register file, lock and kick-key decode (WIN field under WDT_WINDOW_EN)
module wdt_csr
  import soc_pkg::*;
#(
  parameter int TIMEOUT_W   = WDT_TIMEOUT_W,
  parameter int RST_TIMEOUT = 1_000_000
) (
  input  logic                 clk_54,
  input  logic                 srst54_n,
  input  logic                 csr_we,
  input  logic [1:0]           csr_addr,
  input  logic [31:0]          csr_wdata,
  input  logic [TIMEOUT_W-1:0] count_i,
  input  logic [1:0]           state_i,
  output logic [31:0]          csr_rdata,
  output logic [TIMEOUT_W-1:0] timeout_o,
  output logic [7:0]           win_o,
  output logic                 en_set_o,
  output logic                 en_clr_o,
  output logic                 kick_ok_o
);

  logic                 en_q;
  logic                 lock_q;
  logic [TIMEOUT_W-1:0] timeout_q;
  logic [TIMEOUT_W-1:0] timeout_d;
  logic                 ctrl_wr;
  logic                 timeout_wr;

  // Once LOCK is set only a reset can reopen CTRL and TIMEOUT.
  assign ctrl_wr    = csr_we && (csr_addr == WDT_ADDR_CTRL) && !lock_q;
  assign timeout_wr = csr_we && (csr_addr == WDT_ADDR_TIMEOUT) && !lock_q;

  assign en_set_o  = ctrl_wr && csr_wdata[0];
  assign en_clr_o  = ctrl_wr && !csr_wdata[0];
  assign kick_ok_o = csr_we && (csr_addr == WDT_ADDR_KICK) && (csr_wdata == WDT_KICK_KEY);

  assign timeout_o = timeout_q;

  // A zero timeout would bite on the first tick; clamp it to 1us.
  always_comb begin
    timeout_d = timeout_q;
    if (timeout_wr) begin
      timeout_d = (csr_wdata[TIMEOUT_W-1:0] == '0) ? TIMEOUT_W'(1) : csr_wdata[TIMEOUT_W-1:0];
    end
  end

  // CTRL and TIMEOUT storage; LOCK can only be raised.
  always_ff @(posedge clk_54 or negedge srst54_n) begin
    if (!srst54_n) begin
      en_q      <= 1'b0;
      lock_q    <= 1'b0;
      timeout_q <= TIMEOUT_W'(RST_TIMEOUT);
    end else begin
      if (ctrl_wr) begin
        en_q   <= csr_wdata[0];
        lock_q <= csr_wdata[1];
      end
      timeout_q <= timeout_d;
    end
  end

`ifdef WDT_WINDOW_EN
  logic [7:0] win_q;

  // Kick window minimum, in units of 256us, locked together with CTRL.
  always_ff @(posedge clk_54 or negedge srst54_n) begin
    if (!srst54_n) begin
      win_q <= 8'd0;
    end else if (ctrl_wr) begin
      win_q <= csr_wdata[15:8];
    end
  end

  assign win_o = win_q;
`else
  assign win_o = 8'd0;
`endif

  // Read mux, purely combinational from the address.
  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      WDT_ADDR_CTRL: begin
        csr_rdata[0]    = en_q;
        csr_rdata[1]    = lock_q;
        csr_rdata[15:8] = win_o;
      end
      WDT_ADDR_TIMEOUT: csr_rdata[TIMEOUT_W-1:0] = timeout_q;
      WDT_ADDR_STATUS: begin
        csr_rdata[TIMEOUT_W-1:0] = count_i;
        csr_rdata[29:28]         = state_i;
        csr_rdata[31]            = lock_q;
      end
      default: csr_rdata = '0;
    endcase
  end

endmodule

// File: rtl/soc_watchdog.sv
// rtl/soc_watchdog.sv - microsecond watchdog FSM and down-counter (kick window under WDT_WINDOW_EN)
module soc_watchdog
  import soc_pkg::*;
#(
  parameter int TIMEOUT_W   = WDT_TIMEOUT_W,
  parameter int WARN_US     = 1000,
  parameter int RST_TIMEOUT = 1_000_000
) (
  input  logic        clk_54,
  input  logic        srst54_n,
  input  logic        tick_1us,
  input  logic        csr_we,
  input  logic [1:0]  csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        irq_warn,
  output logic        force_rst
);

  wdt_state_t           state_q, state_d;
  logic [TIMEOUT_W-1:0] count_q, count_d;
  logic [TIMEOUT_W-1:0] count_dec;
  logic [TIMEOUT_W-1:0] timeout;
  logic [7:0]           win;
  logic                 en_set, en_clr, kick_ok;
  logic                 win_bad;
  logic [31:0]          elapsed, win_min;
  logic                 force_rst_q;

  wdt_csr #(
    .TIMEOUT_W  (TIMEOUT_W),
    .RST_TIMEOUT(RST_TIMEOUT)
  ) u_csr (
    .clk_54   (clk_54),
    .srst54_n (srst54_n),
    .csr_we   (csr_we),
    .csr_addr (csr_addr),
    .csr_wdata(csr_wdata),
    .count_i  (count_q),
    .state_i  (state_q),
    .csr_rdata(csr_rdata),
    .timeout_o(timeout),
    .win_o    (win),
    .en_set_o (en_set),
    .en_clr_o (en_clr),
    .kick_ok_o(kick_ok)
  );

  // Early-kick detection; a count above TIMEOUT (TIMEOUT lowered after reload) counts as legal.
  always_comb begin
    elapsed = 32'(timeout) - 32'(count_q);
    win_min = {16'd0, win, 8'd0};
    win_bad = (win != 8'd0) && (count_q <= timeout) && (elapsed < win_min);
  end

  // Next state and counter; kick beats a same-cycle tick, BITE is only left by reset.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    count_dec = count_q - TIMEOUT_W'(1);
    case (state_q)
      DISABLED: begin
        if (en_set) begin
          state_d = RUNNING;
          count_d = timeout;
        end
      end
      RUNNING, WARN: begin
        if (en_clr) begin
          state_d = DISABLED;
        end else if (kick_ok) begin
          if (win_bad) begin
            state_d = BITE;
          end else begin
            state_d = RUNNING;
            count_d = timeout;
          end
        end else if (tick_1us) begin
          if (count_q == '0) begin
            state_d = BITE;
          end else begin
            count_d = count_dec;
            if (count_dec <= TIMEOUT_W'(WARN_US)) state_d = WARN;
          end
        end
      end
      default: state_d = state_q;
    endcase
  end

  // State, counter and the registered reset request.
  always_ff @(posedge clk_54 or negedge srst54_n) begin
    if (!srst54_n) begin
      state_q     <= DISABLED;
      count_q     <= TIMEOUT_W'(RST_TIMEOUT);
      force_rst_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      force_rst_q <= (state_q == BITE);
    end
  end

  assign irq_warn  = (state_q == WARN);
  assign force_rst = force_rst_q;

endmodule

// File: tb/tb_soc_watchdog.sv
// tb/tb_soc_watchdog.sv - self-checking bench for soc_watchdog (window cases under WDT_WINDOW_EN)
module tb_soc_watchdog;

  localparam logic [31:0] KEY = 32'h5A5A_A5A5;
  localparam int RST_TO = 1_000_000;
  localparam int WARN_LIM = 1000;

  logic        clk_54 = 1'b0;
  logic        srst54_n;
  logic        tick_1us;
  logic        csr_we;
  logic [1:0]  csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        irq_warn;
  logic        force_rst;

  always #5 clk_54 = ~clk_54;

  soc_watchdog dut (
    .clk_54   (clk_54),
    .srst54_n (srst54_n),
    .tick_1us (tick_1us),
    .csr_we   (csr_we),
    .csr_addr (csr_addr),
    .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata),
    .irq_warn (irq_warn),
    .force_rst(force_rst)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: states 0 disabled, 1 running, 2 warn, 3 bite.
  int m_state, m_count, m_timeout, m_win;
  bit m_en, m_lock, m_frst;

  typedef struct {
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic        tick;
    logic [1:0]  raddr;
    logic [31:0] exp_rd;
    logic        exp_irq;
    logic        exp_frst;
  } vec_t;

  vec_t tbl[19];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_count = RST_TO; m_timeout = RST_TO; m_win = 0;
    m_en = 0; m_lock = 0; m_frst = 0;
  endtask

  task automatic model_edge(input logic we, input logic [1:0] a, input logic [31:0] d, input logic tk);
    int ns, nc;
    bit wr_ctrl, kick, early;
    ns = m_state;
    nc = m_count;
    wr_ctrl = we && (a == 2'd0) && !m_lock;
    kick    = we && (a == 2'd2) && (d == KEY);
    early   = (m_win != 0) && (m_count <= m_timeout) && ((m_timeout - m_count) < m_win * 256);
    if (m_state == 0) begin
      if (wr_ctrl && d[0]) begin ns = 1; nc = m_timeout; end
    end else if (m_state == 1 || m_state == 2) begin
      if (wr_ctrl && !d[0]) ns = 0;
      else if (kick) begin
        if (early) ns = 3;
        else begin ns = 1; nc = m_timeout; end
      end else if (tk) begin
        if (m_count == 0) ns = 3;
        else begin
          nc = m_count - 1;
          if (nc <= WARN_LIM) ns = 2;
        end
      end
    end
    m_frst = (m_state == 3);
    if (wr_ctrl) begin
      m_en = d[0];
      m_lock = d[1];
`ifdef WDT_WINDOW_EN
      m_win = int'(d[15:8]);
`endif
    end
    if (we && (a == 2'd1) && !m_lock) m_timeout = (d[23:0] == 24'd0) ? 1 : int'(d[23:0]);
    m_state = ns;
    m_count = nc;
  endtask

  function automatic logic [31:0] m_read(input logic [1:0] a);
    logic [31:0] r;
    r = '0;
    case (a)
      2'd0: begin r[0] = m_en; r[1] = m_lock; r[15:8] = 8'(m_win); end
      2'd1: r = 32'(m_timeout);
      2'd3: begin r[23:0] = 24'(m_count); r[29:28] = 2'(m_state); r[31] = m_lock; end
      default: r = '0;
    endcase
    return r;
  endfunction

  // Apply one cycle of inputs, advance the model, return at posedge+1.
  task automatic drive(input logic we, input logic [1:0] a, input logic [31:0] d, input logic tk);
    csr_we = we; csr_addr = a; csr_wdata = d; tick_1us = tk;
    model_edge(we, a, d, tk);
    @(posedge clk_54);
    #1;
    csr_we = 1'b0; tick_1us = 1'b0;
  endtask

  task automatic chk_model(input logic [1:0] a);
    csr_addr = a;
    #1;
    chk("rand_rdata", csr_rdata, m_read(a));
    chk("rand_irq", {31'd0, irq_warn}, {31'd0, (m_state == 2)});
    chk("rand_frst", {31'd0, force_rst}, {31'd0, m_frst});
  endtask

  task automatic read_chk(input string nm, input logic [1:0] a, input logic [31:0] exp);
    csr_addr = a;
    #1;
    chk(nm, csr_rdata, exp);
  endtask

  task automatic do_reset();
    csr_we = 1'b0; tick_1us = 1'b0; srst54_n = 1'b0;
    @(posedge clk_54);
    #1;
    srst54_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int warn_at, bite_at;
    bit saw_warn, saw_frst;
    logic [1:0] ra;
    logic [31:0] d;

    srst54_n = 1'b0; csr_we = 1'b0; csr_addr = 2'd0; csr_wdata = '0; tick_1us = 1'b0;
    model_reset();
    @(posedge clk_54);
    #1;
    srst54_n = 1'b1;

    // Reset values.
    read_chk("rst_ctrl", 2'd0, 32'h0);
    read_chk("rst_timeout", 2'd1, 32'h000F_4240);
    read_chk("rst_kick", 2'd2, 32'h0);
    read_chk("rst_status", 2'd3, 32'h000F_4240);
    chk("rst_irq", {31'd0, irq_warn}, 32'd0);
    chk("rst_frst", {31'd0, force_rst}, 32'd0);

    // Directed table: zero timeout clamp, warn entry, bad/good key, kick+tick, disable, bite.
    tbl[0]  = '{1'b1, 2'd1, 32'd3,          1'b0, 2'd1, 32'd3,          1'b0, 1'b0};
    tbl[1]  = '{1'b1, 2'd1, 32'd0,          1'b0, 2'd1, 32'd1,          1'b0, 1'b0};
    tbl[2]  = '{1'b1, 2'd1, 32'd1002,       1'b0, 2'd1, 32'd1002,       1'b0, 1'b0};
    tbl[3]  = '{1'b1, 2'd0, 32'd1,          1'b0, 2'd3, 32'h1000_03EA,  1'b0, 1'b0};
    tbl[4]  = '{1'b0, 2'd0, 32'd0,          1'b1, 2'd3, 32'h1000_03E9,  1'b0, 1'b0};
    tbl[5]  = '{1'b0, 2'd0, 32'd0,          1'b1, 2'd3, 32'h2000_03E8,  1'b1, 1'b0};
    tbl[6]  = '{1'b1, 2'd2, 32'h1234_5678,  1'b0, 2'd3, 32'h2000_03E8,  1'b1, 1'b0};
    tbl[7]  = '{1'b0, 2'd0, 32'd0,          1'b1, 2'd3, 32'h2000_03E7,  1'b1, 1'b0};
    tbl[8]  = '{1'b1, 2'd2, KEY,            1'b1, 2'd3, 32'h1000_03EA,  1'b0, 1'b0};
    tbl[9]  = '{1'b1, 2'd0, 32'd0,          1'b1, 2'd3, 32'h0000_03EA,  1'b0, 1'b0};
    tbl[10] = '{1'b0, 2'd0, 32'd0,          1'b1, 2'd3, 32'h0000_03EA,  1'b0, 1'b0};
    tbl[11] = '{1'b1, 2'd2, KEY,            1'b0, 2'd3, 32'h0000_03EA,  1'b0, 1'b0};
    tbl[12] = '{1'b1, 2'd1, 32'd1,          1'b0, 2'd1, 32'd1,          1'b0, 1'b0};
    tbl[13] = '{1'b1, 2'd0, 32'd1,          1'b0, 2'd3, 32'h1000_0001,  1'b0, 1'b0};
    tbl[14] = '{1'b0, 2'd0, 32'd0,          1'b1, 2'd3, 32'h2000_0000,  1'b1, 1'b0};
    tbl[15] = '{1'b0, 2'd0, 32'd0,          1'b1, 2'd3, 32'h3000_0000,  1'b0, 1'b0};
    tbl[16] = '{1'b1, 2'd0, 32'd0,          1'b1, 2'd3, 32'h3000_0000,  1'b0, 1'b1};
    tbl[17] = '{1'b1, 2'd2, KEY,            1'b1, 2'd3, 32'h3000_0000,  1'b0, 1'b1};
    tbl[18] = '{1'b0, 2'd0, 32'd0,          1'b0, 2'd0, 32'h0,          1'b0, 1'b1};
    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].tick);
      csr_addr = tbl[i].raddr;
      #1;
      chk($sformatf("tbl%0d_rdata", i), csr_rdata, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_irq", i), {31'd0, irq_warn}, {31'd0, tbl[i].exp_irq});
      chk($sformatf("tbl%0d_frst", i), {31'd0, force_rst}, {31'd0, tbl[i].exp_frst});
    end

    // Asynchronous reset while biting: outputs clear with no clock edge.
    srst54_n = 1'b0;
    #1;
    chk("async_frst", {31'd0, force_rst}, 32'd0);
    chk("async_irq", {31'd0, irq_warn}, 32'd0);
    read_chk("async_status", 2'd3, 32'h000F_4240);
    read_chk("async_timeout", 2'd1, 32'h000F_4240);
    @(posedge clk_54);
    #1;
    srst54_n = 1'b1;
    model_reset();

    // Lock: EN=0 and TIMEOUT writes are ignored afterwards.
    do_reset();
    drive(1'b1, 2'd0, 32'd3, 1'b0);
    drive(1'b1, 2'd0, 32'd0, 1'b0);
    drive(1'b1, 2'd1, 32'd10, 1'b0);
    read_chk("lock_status", 2'd3, 32'h900F_4240);
    read_chk("lock_timeout", 2'd1, 32'h000F_4240);
    read_chk("lock_ctrl", 2'd0, 32'h3);

    // No kicks: WARN after 4000 ticks, BITE on tick 5001, force_rst one edge later.
    do_reset();
    drive(1'b1, 2'd1, 32'd5000, 1'b0);
    drive(1'b1, 2'd0, 32'd1, 1'b0);
    warn_at = -1;
    bite_at = -1;
    for (int k = 1; k <= 6000 && bite_at < 0; k++) begin
      drive(1'b0, 2'd0, 32'd0, 1'b1);
      csr_addr = 2'd3;
      #1;
      if (warn_at < 0 && irq_warn) warn_at = k;
      if (csr_rdata[29:28] == 2'd3) bite_at = k;
    end
    chk("nokick_warn_tick", 32'(warn_at), 32'd4000);
    chk("nokick_bite_tick", 32'(bite_at), 32'd5001);
    chk("nokick_frst_lag", {31'd0, force_rst}, 32'd0);
    drive(1'b0, 2'd0, 32'd0, 1'b0);
    chk("nokick_frst", {31'd0, force_rst}, 32'd1);

    // Kick every 3000 ticks for 50k ticks: never warns, never bites.
    do_reset();
    drive(1'b1, 2'd1, 32'd5000, 1'b0);
    drive(1'b1, 2'd0, 32'd1, 1'b0);
    saw_warn = 0;
    saw_frst = 0;
    for (int k = 1; k <= 50000; k++) begin
      drive((k % 3000) == 0, 2'd2, KEY, 1'b1);
      saw_warn |= irq_warn;
      saw_frst |= force_rst;
    end
    chk("kick_never_warn", {31'd0, saw_warn}, 32'd0);
    chk("kick_never_frst", {31'd0, saw_frst}, 32'd0);
    read_chk("kick_status", 2'd3, 32'h1000_0000 | 32'(5000 - (50000 % 3000)));

    // Kick window: WIN=4 means at least 1024us must elapse before a kick.
    do_reset();
    drive(1'b1, 2'd1, 32'd5000, 1'b0);
    drive(1'b1, 2'd0, 32'h0000_0401, 1'b0);
`ifdef WDT_WINDOW_EN
    read_chk("win_ctrl", 2'd0, 32'h0000_0401);
`else
    read_chk("win_ctrl", 2'd0, 32'h0000_0001);
`endif
    for (int k = 0; k < 500; k++) drive(1'b0, 2'd0, 32'd0, 1'b1);
    drive(1'b1, 2'd2, KEY, 1'b0);
`ifdef WDT_WINDOW_EN
    read_chk("win_early", 2'd3, 32'h3000_1194);
    do_reset();
    drive(1'b1, 2'd1, 32'd5000, 1'b0);
    drive(1'b1, 2'd0, 32'h0000_0401, 1'b0);
    for (int k = 0; k < 1100; k++) drive(1'b0, 2'd0, 32'd0, 1'b1);
    drive(1'b1, 2'd2, KEY, 1'b0);
    read_chk("win_late", 2'd3, 32'h1000_1388);
`else
    read_chk("win_ignored", 2'd3, 32'h1000_1388);
`endif

    // Randomized traffic against the reference model.
    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int c = 0; c < 1500; c++) begin
        ra = 2'($urandom_range(0, 3));
        case (ra)
          2'd0: begin
            d = '0;
            d[0] = ($urandom_range(0, 3) != 0);
            d[1] = ($urandom_range(0, 31) == 0);
            d[15:8] = 8'($urandom_range(0, 5));
          end
          2'd1: d = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 2500));
          2'd2: d = ($urandom_range(0, 3) != 0) ? KEY : $urandom;
          default: d = $urandom;
        endcase
        drive($urandom_range(0, 3) == 0, ra, d, 1'($urandom_range(0, 1)));
        chk_model(2'($urandom_range(0, 3)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
